// File: rtl/vdma_axi_pkg.sv
// Shared state encoding, AXI constants and helpers for the VDMA AXI state cores.
package vdma_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StDone
    } axi_state_e;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [3:0]  CACHE_DEF  = 4'b0011;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam int unsigned WDOG_W     = 10;

    // AXI AxSIZE encoding for a data bus of dsize bits.
    function automatic logic [2:0] axi_size(input int unsigned dsize);
        return 3'($clog2(dsize / 8));
    endfunction

endpackage

// File: rtl/axi_wr_beat_counter.sv
// Counts accepted W beats of the current burst and flags the beat that must carry WLAST.
module axi_wr_beat_counter #(
    parameter int unsigned LSIZE = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_incr,
    input  logic [LSIZE-1:0] i_len,
    output logic             o_last
);

    logic [LSIZE-1:0] r_count;
    logic [LSIZE-1:0] w_count_nxt;

    // Clear wins: it fires on AW accept, before any beat of the burst can handshake.
    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = '0;
        end else if (i_incr) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_last = (r_count == i_len);

endmodule

// File: rtl/axi_inf_write_state_core.sv
// AXI4 write burst engine: one AW per request, W beats from a show-ahead FIFO, then B.
// Optional macro AXI_WR_TIMEOUT_EN adds a watchdog on the B-response wait.
module axi_inf_write_state_core
    import vdma_axi_pkg::*;
#(
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned ID        = 0,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned ASIZE     = 29,
    parameter int unsigned AXI_DSIZE = 256
) (
    input  logic                   axi_aclk,
    input  logic                   axi_resetn,
    input  logic                   write_req,
    input  logic [LSIZE-1:0]       req_len,
    input  logic [ASIZE-1:0]       req_addr,
    output logic                   req_resp,
    output logic                   req_done,
    output logic                   req_err,
    output logic                   pull_data_en,
    input  logic [AXI_DSIZE-1:0]   wdata_in,
    input  logic                   wdata_valid,
    output logic [IDSIZE-1:0]      axi_awid,
    output logic [ASIZE-1:0]       axi_awaddr,
    output logic [LSIZE-1:0]       axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic [1:0]             axi_awburst,
    output logic                   axi_awlock,
    output logic [3:0]             axi_awcache,
    output logic [2:0]             axi_awprot,
    output logic [3:0]             axi_awqos,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [AXI_DSIZE-1:0]   axi_wdata,
    output logic [AXI_DSIZE/8-1:0] axi_wstrb,
    output logic                   axi_wlast,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    input  logic [IDSIZE-1:0]      axi_bid,
    input  logic [1:0]             axi_bresp,
    input  logic                   axi_bvalid,
    output logic                   axi_bready
);

    localparam logic [IDSIZE-1:0] ID_V = IDSIZE'(ID);

    axi_state_e       r_state, w_state_nxt;
    logic             r_awvalid, w_awvalid_nxt;
    logic             r_bready, w_bready_nxt;
    logic             r_req_resp, w_req_resp_nxt;
    logic             r_req_done, w_req_done_nxt;
    logic             r_req_err, w_req_err_nxt;
    logic [ASIZE-1:0] r_awaddr, w_awaddr_nxt;
    logic [LSIZE-1:0] r_awlen, w_awlen_nxt;

    logic w_aw_hs;
    logic w_wvalid;
    logic w_w_hs;
    logic w_last;
    logic w_cnt_clear;
    logic w_b_hs;
    logic w_b_err;
    logic w_unused_bresp0;

    assign w_aw_hs  = r_awvalid & axi_awready;
    assign w_wvalid = (r_state == StData) & wdata_valid;
    assign w_w_hs   = w_wvalid & axi_wready;
    assign w_b_hs   = r_bready & axi_bvalid;
    // Only SLVERR/DECERR count as failures; EXOKAY is not expected but is benign.
    assign w_b_err  = axi_bresp[1] | (axi_bid != ID_V);
    assign w_unused_bresp0 = axi_bresp[0];

    axi_wr_beat_counter #(
        .LSIZE (LSIZE)
    ) u_beat_counter (
        .i_clk   (axi_aclk),
        .i_rst_n (axi_resetn),
        .i_clear (w_cnt_clear),
        .i_incr  (w_w_hs),
        .i_len   (r_awlen),
        .o_last  (w_last)
    );

`ifdef AXI_WR_TIMEOUT_EN
    logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
    logic              w_wdog_expired;

    assign w_wdog_expired = (r_wdog == '1);

    always_comb begin
        w_wdog_nxt = '0;
        if (r_state == StResp) begin
            w_wdog_nxt = r_wdog + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end
`else
    logic w_wdog_expired;
    assign w_wdog_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_awvalid_nxt  = r_awvalid;
        w_bready_nxt   = r_bready;
        w_req_resp_nxt = 1'b0;
        w_req_done_nxt = 1'b0;
        w_req_err_nxt  = r_req_err;
        w_awaddr_nxt   = r_awaddr;
        w_awlen_nxt    = r_awlen;
        w_cnt_clear    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (write_req) begin
                    w_awaddr_nxt   = req_addr;
                    w_awlen_nxt    = req_len;
                    w_req_resp_nxt = 1'b1;
                    w_awvalid_nxt  = 1'b1;
                    w_state_nxt    = StAddr;
                end
            end
            StAddr: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_cnt_clear   = 1'b1;
                    w_state_nxt   = StData;
                end
            end
            StData: begin
                if (w_w_hs && w_last) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = StResp;
                end
            end
            StResp: begin
                if (w_b_hs) begin
                    w_bready_nxt   = 1'b0;
                    w_req_done_nxt = 1'b1;
                    w_state_nxt    = StDone;
                    if (w_b_err) begin
                        w_req_err_nxt = 1'b1;
                    end
                end else if (w_wdog_expired) begin
                    w_bready_nxt   = 1'b0;
                    w_req_done_nxt = 1'b1;
                    w_req_err_nxt  = 1'b1;
                    w_state_nxt    = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state    <= StIdle;
            r_awvalid  <= 1'b0;
            r_bready   <= 1'b0;
            r_req_resp <= 1'b0;
            r_req_done <= 1'b0;
            r_req_err  <= 1'b0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_bready   <= w_bready_nxt;
            r_req_resp <= w_req_resp_nxt;
            r_req_done <= w_req_done_nxt;
            r_req_err  <= w_req_err_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_awlen    <= w_awlen_nxt;
        end
    end

    assign req_resp     = r_req_resp;
    assign req_done     = r_req_done;
    assign req_err      = r_req_err;
    assign pull_data_en = w_w_hs;

    assign axi_awid     = ID_V;
    assign axi_awaddr   = r_awaddr;
    assign axi_awlen    = r_awlen;
    assign axi_awsize   = axi_size(AXI_DSIZE);
    assign axi_awburst  = BURST_INCR;
    assign axi_awlock   = 1'b0;
    assign axi_awcache  = CACHE_DEF;
    assign axi_awprot   = 3'b000;
    assign axi_awqos    = 4'b0000;
    assign axi_awvalid  = r_awvalid;

    assign axi_wdata    = wdata_in;
    assign axi_wstrb    = '1;
    assign axi_wlast    = (r_state == StData) & w_last;
    assign axi_wvalid   = w_wvalid;
    assign axi_bready   = r_bready;

endmodule

// File: tb/tb_axi_inf_write_state_core.sv
// Scoreboard bench for axi_inf_write_state_core; the B-wait test adapts to AXI_WR_TIMEOUT_EN.
module tb_axi_inf_write_state_core;

    localparam int unsigned IDSIZE = 4;
    localparam int unsigned ID     = 0;
    localparam int unsigned LSIZE  = 9;
    localparam int unsigned ASIZE  = 29;
    localparam int unsigned DW     = 256;

    logic              axi_aclk = 1'b0;
    logic              axi_resetn = 1'b0;
    logic              write_req;
    logic [LSIZE-1:0]  req_len;
    logic [ASIZE-1:0]  req_addr;
    logic              req_resp, req_done, req_err, pull_data_en;
    logic [DW-1:0]     wdata_in;
    logic              wdata_valid;
    logic [IDSIZE-1:0] axi_awid;
    logic [ASIZE-1:0]  axi_awaddr;
    logic [LSIZE-1:0]  axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awlock;
    logic [3:0]        axi_awcache;
    logic [2:0]        axi_awprot;
    logic [3:0]        axi_awqos;
    logic              axi_awvalid, axi_awready;
    logic [DW-1:0]     axi_wdata;
    logic [DW/8-1:0]   axi_wstrb;
    logic              axi_wlast, axi_wvalid, axi_wready;
    logic [IDSIZE-1:0] axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid, axi_bready;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_inf_write_state_core #(
        .IDSIZE    (IDSIZE),
        .ID        (ID),
        .LSIZE     (LSIZE),
        .ASIZE     (ASIZE),
        .AXI_DSIZE (DW)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_resetn   (axi_resetn),
        .write_req    (write_req),
        .req_len      (req_len),
        .req_addr     (req_addr),
        .req_resp     (req_resp),
        .req_done     (req_done),
        .req_err      (req_err),
        .pull_data_en (pull_data_en),
        .wdata_in     (wdata_in),
        .wdata_valid  (wdata_valid),
        .axi_awid     (axi_awid),
        .axi_awaddr   (axi_awaddr),
        .axi_awlen    (axi_awlen),
        .axi_awsize   (axi_awsize),
        .axi_awburst  (axi_awburst),
        .axi_awlock   (axi_awlock),
        .axi_awcache  (axi_awcache),
        .axi_awprot   (axi_awprot),
        .axi_awqos    (axi_awqos),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wlast    (axi_wlast),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bid      (axi_bid),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic clear_inputs();
        write_req   = 1'b0;
        req_len     = '0;
        req_addr    = '0;
        wdata_in    = '0;
        wdata_valid = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bid     = '0;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
        fifo_q.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge axi_aclk);
        axi_resetn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
    endtask

    // Drives one complete request; b_delay < 0 returns once RESP is entered,
    // abort_at >= 0 returns right after that many W handshakes.
    task automatic do_burst(input string tag, input int len, input logic [ASIZE-1:0] addr,
                            input int aw_delay, input bit toggle_valid, input bit rand_ready,
                            input logic [1:0] bresp, input logic [IDSIZE-1:0] bid,
                            input int b_delay, input bit exp_err, input int abort_at);
        int c;
        int beats;
        bit tog;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] drop_d;
        for (int i = 0; i <= len; i++) begin
            exp_d = rand_data();
            fifo_q.push_back(exp_d);
            exp_q.push_back(exp_d);
        end
        @(negedge axi_aclk);
        write_req   = 1'b1;
        req_len     = LSIZE'(len);
        req_addr    = addr;
        wdata_valid = 1'b1;
        wdata_in    = fifo_q[0];
        @(posedge axi_aclk);
        #1;
        n_checks++;
        if (req_resp !== 1'b1 || axi_awvalid !== 1'b1 || axi_awaddr !== addr ||
            axi_awlen !== LSIZE'(len) || axi_awsize !== 3'd5) begin
            n_fails++;
            $display("FAIL %s accept: req_resp=%b awvalid=%b awaddr=%h awlen=%0d awsize=%0d, required 1 1 %h %0d 5",
                     tag, req_resp, axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, addr, len);
        end
        @(negedge axi_aclk);
        write_req = 1'b0;
        c = 0;
        forever begin
            axi_awready = (c >= aw_delay);
            #1;
            n_checks++;
            if (axi_awvalid !== 1'b1 || axi_awaddr !== addr || axi_awlen !== LSIZE'(len) ||
                axi_wvalid !== 1'b0) begin
                n_fails++;
                $display("FAIL %s aw_wait c=%0d: awvalid=%b awaddr=%h awlen=%0d wvalid=%b, required 1 %h %0d 0",
                         tag, c, axi_awvalid, axi_awaddr, axi_awlen, axi_wvalid, addr, len);
            end
            @(posedge axi_aclk);
            if (axi_awready) break;
            c++;
            @(negedge axi_aclk);
        end
        beats = 0;
        tog = 1'b0;
        c = 0;
        while (beats <= len) begin
            @(negedge axi_aclk);
            axi_awready = 1'b0;
            tog = ~tog;
            wdata_valid = (fifo_q.size() != 0) && (!toggle_valid || tog);
            wdata_in    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
            axi_wready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            n_checks++;
            if (axi_wvalid !== wdata_valid) begin
                n_fails++;
                $display("FAIL %s wvalid beat=%0d: got %b, required %b", tag, beats, axi_wvalid,
                         wdata_valid);
            end
            if (wdata_valid && axi_wready) begin
                exp_d = exp_q.pop_front();
                n_checks++;
                if (pull_data_en !== 1'b1 || axi_wdata !== exp_d || axi_wlast !== 1'(beats == len)) begin
                    n_fails++;
                    $display("FAIL %s beat=%0d: pull=%b wlast=%b wdata=%h, required 1 %b %h",
                             tag, beats, pull_data_en, axi_wlast, axi_wdata, beats == len, exp_d);
                end
                drop_d = fifo_q.pop_front();
                beats++;
            end else begin
                n_checks++;
                if (pull_data_en !== 1'b0) begin
                    n_fails++;
                    $display("FAIL %s idle_pull beat=%0d: got %b, required 0", tag, beats, pull_data_en);
                end
            end
            @(posedge axi_aclk);
            if (beats == abort_at) return;
            c++;
            if (c > 300) begin
                n_fails++;
                $display("FAIL %s w_timeout: beats=%0d, required %0d", tag, beats, len + 1);
                return;
            end
        end
        @(negedge axi_aclk);
        axi_wready  = 1'b1;
        wdata_valid = 1'b1;
        wdata_in    = rand_data();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL %s leftover: %0d beats unsent, required 0", tag, exp_q.size());
        end
        if (b_delay < 0) return;
        for (int i = 0; i < b_delay; i++) begin
            #1;
            n_checks++;
            if (axi_bready !== 1'b1 || req_done !== 1'b0 || axi_wvalid !== 1'b0 ||
                pull_data_en !== 1'b0) begin
                n_fails++;
                $display("FAIL %s b_wait: bready=%b done=%b wvalid=%b pull=%b, required 1 0 0 0",
                         tag, axi_bready, req_done, axi_wvalid, pull_data_en);
            end
            @(negedge axi_aclk);
        end
        axi_bvalid = 1'b1;
        axi_bresp  = bresp;
        axi_bid    = bid;
        #1;
        n_checks++;
        if (axi_bready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s bready: got %b, required 1", tag, axi_bready);
        end
        @(posedge axi_aclk);
        #1;
        n_checks++;
        if (req_done !== 1'b1 || axi_bready !== 1'b0 || req_err !== exp_err) begin
            n_fails++;
            $display("FAIL %s done: req_done=%b bready=%b req_err=%b, required 1 0 %b",
                     tag, req_done, axi_bready, req_err, exp_err);
        end
        @(negedge axi_aclk);
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
        axi_bid     = '0;
        wdata_valid = 1'b0;
        axi_wready  = 1'b0;
        @(posedge axi_aclk);
        #1;
        n_checks++;
        if (req_done !== 1'b0 || axi_awvalid !== 1'b0) begin
            n_fails++;
            $display("FAIL %s done_pulse: req_done=%b awvalid=%b, required 0 0", tag, req_done,
                     axi_awvalid);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        clear_inputs();
        d = rand_data();
        wdata_in = d;
        #2;
        n_checks++;
        if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_bready !== 1'b0 ||
            req_resp !== 1'b0 || req_done !== 1'b0 || req_err !== 1'b0 || pull_data_en !== 1'b0 ||
            axi_awaddr !== '0 || axi_awlen !== '0 || axi_wlast !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state: awv=%b wv=%b br=%b resp=%b done=%b err=%b pull=%b addr=%h len=%0d wlast=%b, required all 0",
                     axi_awvalid, axi_wvalid, axi_bready, req_resp, req_done, req_err,
                     pull_data_en, axi_awaddr, axi_awlen, axi_wlast);
        end
        n_checks++;
        if (axi_awid !== 4'd0 || axi_awsize !== 3'd5 || axi_awburst !== 2'b01 ||
            axi_awcache !== 4'b0011 || axi_awlock !== 1'b0 || axi_awprot !== 3'd0 ||
            axi_awqos !== 4'd0 || axi_wstrb !== {(DW/8){1'b1}} || axi_wdata !== d) begin
            n_fails++;
            $display("FAIL constants: id=%0d size=%0d burst=%b cache=%b lock=%b prot=%0d qos=%0d strb=%h, required 0 5 01 0011 0 0 0 all-ones",
                     axi_awid, axi_awsize, axi_awburst, axi_awcache, axi_awlock, axi_awprot,
                     axi_awqos, axi_wstrb);
        end
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        repeat (3) @(posedge axi_aclk);
        #1;
        n_checks++;
        if (axi_awvalid !== 1'b0 || req_resp !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_no_req: awvalid=%b req_resp=%b, required 0 0", axi_awvalid, req_resp);
        end
    endtask

    task automatic test_burst16();
        do_burst("burst16", 15, 29'h1000, 3, 1'b0, 1'b0, 2'b00, 4'h0, 2, 1'b0, -1);
    endtask

    task automatic test_single_beat();
        do_burst("single", 0, 29'h0040, 0, 1'b0, 1'b0, 2'b00, 4'h0, 0, 1'b0, -1);
    endtask

    task automatic test_stall_backpressure();
        do_burst("stall8", 7, 29'h0800, 1, 1'b1, 1'b1, 2'b00, 4'h0, 1, 1'b0, -1);
    endtask

    task automatic test_back_to_back_err();
        do_burst("slverr", 3, 29'h0100, 0, 1'b0, 1'b0, 2'b10, 4'h0, 0, 1'b1, -1);
        do_burst("sticky", 1, 29'h0200, 2, 1'b0, 1'b0, 2'b00, 4'h0, 1, 1'b1, -1);
    endtask

    task automatic test_reset_mid_burst();
        do_burst("midrst", 15, 29'h2000, 1, 1'b0, 1'b0, 2'b00, 4'h0, 0, 1'b0, 5);
        #2;
        axi_resetn = 1'b0;
        #1;
        n_checks++;
        if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_bready !== 1'b0 ||
            req_resp !== 1'b0 || req_done !== 1'b0 || req_err !== 1'b0 || pull_data_en !== 1'b0 ||
            axi_awaddr !== '0 || axi_awlen !== '0 || axi_wlast !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: awv=%b wv=%b br=%b resp=%b done=%b err=%b pull=%b addr=%h len=%0d wlast=%b, required all 0",
                     axi_awvalid, axi_wvalid, axi_bready, req_resp, req_done, req_err,
                     pull_data_en, axi_awaddr, axi_awlen, axi_wlast);
        end
        clear_inputs();
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        do_burst("postrst", 3, 29'h3000, 0, 1'b0, 1'b0, 2'b00, 4'h0, 0, 1'b0, -1);
    endtask

    task automatic test_bid_mismatch();
        do_burst("badbid", 1, 29'h0400, 0, 1'b0, 1'b0, 2'b00, 4'h3, 0, 1'b1, -1);
    endtask

    task automatic test_resp_wait();
        int n;
        bit seen;
        apply_reset();
        do_burst("bwait", 0, 29'h0600, 0, 1'b0, 1'b0, 2'b00, 4'h0, -1, 1'b0, -1);
        seen = 1'b0;
        n = 0;
        while (n < 5000 && !seen) begin
            @(posedge axi_aclk);
            #1;
            n++;
            if (req_done === 1'b1) seen = 1'b1;
        end
`ifdef AXI_WR_TIMEOUT_EN
        n_checks++;
        if (!seen || n != 1024 || req_err !== 1'b1 || axi_bready !== 1'b0) begin
            n_fails++;
            $display("FAIL watchdog: seen=%b cycles=%0d err=%b bready=%b, required 1 1024 1 0",
                     seen, n, req_err, axi_bready);
        end
`else
        n_checks++;
        if (seen || axi_bready !== 1'b1) begin
            n_fails++;
            $display("FAIL no_watchdog: req_done seen=%b after %0d cycles bready=%b, required 0 1",
                     seen, n, axi_bready);
        end
`endif
        apply_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_burst16();
        test_single_beat();
        test_stall_backpressure();
        test_back_to_back_err();
        test_reset_mid_burst();
        test_bid_mismatch();
        test_resp_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_inf_write_state_core.md
Name: axi_inf_write_state_core

Overview:
- AXI4 write-channel burst engine; write-side counterpart of the VDMA read state core.
- Accepts one burst request (address + length) from the write FIFO status controller and issues one AW transaction.
- Streams W beats from a show-ahead write FIFO, collects the B response, and signals completion.
- Sits between the stream-to-memory FIFO and the AXI interconnect in the memory-write path.

Parameters:
IDSIZE, 4, AXI ID width
ID, 0, constant value driven on axi_awid and expected on axi_bid
LSIZE, 9, burst length field width
ASIZE, 29, address width
AXI_DSIZE, 256, AXI data width in bits (power of 2, 8..1024)

Ports:
axi_aclk  in  1  sole clock
axi_resetn  in  1  asynchronous active-low reset
write_req  in  1  burst request level, sampled in IDLE
req_len  in  LSIZE  beats minus 1 (AXI awlen encoding)
req_addr  in  ASIZE  burst start byte address
req_resp  out  1  one-cycle pulse: request accepted
req_done  out  1  one-cycle pulse: B response received
req_err  out  1  sticky: bad bresp or bid seen; cleared by reset only
pull_data_en  out  1  FIFO read strobe (= W handshake)
wdata_in  in  AXI_DSIZE  FIFO show-ahead data
wdata_valid  in  1  FIFO not empty
axi_awid  out  IDSIZE  = ID
axi_awaddr  out  ASIZE  registered req_addr
axi_awlen  out  LSIZE  registered req_len
axi_awsize  out  3  log2(AXI_DSIZE/8)
axi_awburst  out  2  2'b01 INCR
axi_awlock  out  1  0
axi_awcache  out  4  4'b0011
axi_awprot  out  3  0
axi_awqos  out  4  0
axi_awvalid  out  1  address valid
axi_awready  in  1  address ready
axi_wdata  out  AXI_DSIZE  = wdata_in
axi_wstrb  out  AXI_DSIZE/8  all ones
axi_wlast  out  1  final beat of burst
axi_wvalid  out  1  data valid
axi_wready  in  1  data ready
axi_bid  in  IDSIZE  response ID
axi_bresp  in  2  response code
axi_bvalid  in  1  response valid
axi_bready  out  1  response ready

Behaviour:
- Reset: state IDLE; awvalid, wvalid, bready, req_resp, req_done, req_err, and the beat counter are all 0; awaddr and awlen are 0.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE & write_req:
  - Latch req_addr/req_len; req_resp=1 for one cycle.
  - Next state ADDR, with awvalid=1 registered in the same edge.
- ADDR:
  - awvalid held high with stable addr/len until awready.
  - On awvalid&awready: awvalid cleared, beat counter cleared, go to DATA.
  - No W beat is issued before AW is accepted.
- DATA:
  - axi_wvalid = (state==DATA) & wdata_valid (combinational); pull_data_en = axi_wvalid & axi_wready.
  - Each handshake increments the beat counter (LSIZE bits).
  - axi_wlast = (count == awlen) while in DATA.
  - A handshake with wlast goes to RESP with bready=1 registered.
  - An empty FIFO simply stalls; wvalid never drops mid-beat while wdata_valid is high.
- RESP:
  - bready=1; on bvalid, bready=0 and go to DONE.
  - req_err is set if bresp[1]==1 (SLVERR/DECERR) or bid!=ID.
- DONE: req_done=1 for one cycle; return to IDLE.
- Request throughput: the earliest next write_req acceptance is the cycle after DONE. write_req outside IDLE is ignored (no queuing).
- Burst size: req_len=0 gives a single-beat burst with wlast on the first beat. The maximum is 2^LSIZE-1, and the requester must respect the AXI 256-beat limit.
- Reset mid-burst: asynchronous return to IDLE with all outputs at reset values; the partial burst is abandoned and the interconnect must be reset with it.

Optional Feature:
- Macro: AXI_WR_TIMEOUT_EN.
- Defined:
  - A 10-bit watchdog counts cycles in RESP.
  - On reaching 1023 without bvalid: go to DONE, pulse req_done, set req_err, and drop bready.
- Undefined:
  - RESP waits indefinitely.
  - No watchdog logic is built.

Decomposition:
- Shared package vdma_axi_pkg holds:
  - The state enum.
  - AXI constants: BURST_INCR=2'b01, CACHE_DEF=4'b0011, RESP_OKAY=2'b00.
  - A clog2-based size function for awsize.
- One sub-module, axi_wr_beat_counter: beat count, wlast compare, and clear on AW accept.
- All other logic stays in the FSM.

Test Plan:
- req_len=15, addr=0x1000, awready after 3 cycles, FIFO always valid, wready=1 → one AW (awlen=15, awsize=5 for 256b), 16 W beats, wlast only on beat 16, 16 pull_data_en, req_done 1 cycle after bvalid.
- req_len=0 → single beat carries wlast; req_done follows bvalid; req_resp→req_done sequence intact.
- req_len=7 with wdata_valid toggling every other cycle and wready random → exactly 8 handshakes, wdata matches FIFO order, wlast on the 8th handshake only.
- bresp=2'b10 on the first burst, OKAY on the second → req_err set after the first and still set after the second.
- Reset asserted after 5 of 16 beats → all outputs 0 immediately; after release, a new req_len=3 burst completes cleanly.
- AXI_WR_TIMEOUT_EN defined, bvalid never asserted → req_done and req_err both observed 1024 cycles after entering RESP; without the macro no req_done occurs within 5000 cycles.
